// File: rtl/adder_checker.sv
// adder_checker: on-line checker for a WIDTH-bit adder.
//
// After a start pulse the block compares every valid sample {cout,s}
// against a + b + cin computed at WIDTH+1 bits, counting samples and
// mismatches. The run ends on the edge that accepts sample NUM_VECTORS.
//
// Optional feature (define ADDER_CHECKER_FIRST_FAIL_EN): captures the
// operands, expected and observed results and sample index of the first
// mismatch of each run on the ff_* ports.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             one-cycle pulse that begins a run (ignored in RUN)
//   vld               a/b/cin/s/cout sample valid this cycle
//   a, b, cin         adder inputs
//   s, cout           adder outputs under check
//   busy, done, pass  run status (decoded from registered state/counters)
//   err               one-cycle pulse, one cycle after a mismatching sample
//   vec_cnt, err_cnt  samples checked / mismatches found this run
//   ff_*              first-failure capture (optional feature only)
module adder_checker #(
    parameter int WIDTH       = 4,
    parameter int NUM_VECTORS = 33,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             vld,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [WIDTH-1:0] s,
    input  logic             cout,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             err,
    output logic [CNT_W-1:0] vec_cnt,
    output logic [CNT_W-1:0] err_cnt
`ifdef ADDER_CHECKER_FIRST_FAIL_EN
    ,
    output logic             ff_vld,
    output logic [WIDTH-1:0] ff_a,
    output logic [WIDTH-1:0] ff_b,
    output logic             ff_cin,
    output logic [WIDTH:0]   ff_exp,
    output logic [WIDTH:0]   ff_got,
    output logic [CNT_W-1:0] ff_idx
`endif
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state, state_nxt;
    logic           begin_run;
    logic           accept;
    logic           last;
    logic           mismatch;
    logic [WIDTH:0] expected;
    logic [WIDTH:0] got;

    always_comb begin
        expected = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
        got      = {cout, s};
        mismatch = (expected != got);
    end

    // vec_cnt still holds the pre-increment count on the accepting edge
    assign last = (vec_cnt == CNT_W'(NUM_VECTORS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        begin_run = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    begin_run = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (vld) begin
                    accept = 1'b1;
                    if (last) state_nxt = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    begin_run = 1'b1;
                    state_nxt = RUN;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Status outputs decode flops only, so no input reaches them combinationally
    assign busy = (state == RUN);
    assign done = (state == DONE);
    assign pass = (state == DONE) && (err_cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_cnt <= '0;
            err_cnt <= '0;
            err     <= 1'b0;
        end else if (begin_run) begin
            vec_cnt <= '0;
            err_cnt <= '0;
            err     <= 1'b0;
        end else if (accept) begin
            vec_cnt <= vec_cnt + CNT_W'(1);
            err     <= mismatch;
            if (mismatch && (err_cnt != '1))
                err_cnt <= err_cnt + CNT_W'(1);
        end else begin
            err <= 1'b0;
        end
    end

`ifdef ADDER_CHECKER_FIRST_FAIL_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff_vld <= 1'b0;
            ff_a   <= '0;
            ff_b   <= '0;
            ff_cin <= 1'b0;
            ff_exp <= '0;
            ff_got <= '0;
            ff_idx <= '0;
        end else if (begin_run) begin
            ff_vld <= 1'b0;
            ff_a   <= '0;
            ff_b   <= '0;
            ff_cin <= 1'b0;
            ff_exp <= '0;
            ff_got <= '0;
            ff_idx <= '0;
        end else if (accept && mismatch && !ff_vld) begin
            ff_vld <= 1'b1;
            ff_a   <= a;
            ff_b   <= b;
            ff_cin <= cin;
            ff_exp <= expected;
            ff_got <= got;
            ff_idx <= vec_cnt;
        end
    end
`endif

endmodule

// File: tb/tb_adder_checker.sv
// tb_adder_checker: directed bench for adder_checker. A default instance
// covers the main run, error reporting, mid-run reset and ignored inputs;
// a CNT_W=2 / NUM_VECTORS=3 instance covers back-to-back all-wrong runs.
module tb_adder_checker;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, vld, start2, vld2;
    logic [3:0] a, b, s;
    logic       cin, cout;

    logic       busy, done, pass, err;
    logic [7:0] vec_cnt, err_cnt;
    logic       busy2, done2, pass2, err2;
    logic [1:0] vec_cnt2, err_cnt2;
`ifdef ADDER_CHECKER_FIRST_FAIL_EN
    logic       ff_vld, ff_cin, ff_vld2, ff_cin2;
    logic [3:0] ff_a, ff_b, ff_a2, ff_b2;
    logic [4:0] ff_exp, ff_got, ff_exp2, ff_got2;
    logic [7:0] ff_idx;
    logic [1:0] ff_idx2;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    adder_checker #(.WIDTH(4), .NUM_VECTORS(33), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .vld(vld),
        .a(a), .b(b), .cin(cin), .s(s), .cout(cout),
        .busy(busy), .done(done), .pass(pass), .err(err),
        .vec_cnt(vec_cnt), .err_cnt(err_cnt)
`ifdef ADDER_CHECKER_FIRST_FAIL_EN
        , .ff_vld(ff_vld), .ff_a(ff_a), .ff_b(ff_b), .ff_cin(ff_cin),
        .ff_exp(ff_exp), .ff_got(ff_got), .ff_idx(ff_idx)
`endif
    );

    adder_checker #(.WIDTH(4), .NUM_VECTORS(3), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .vld(vld2),
        .a(a), .b(b), .cin(cin), .s(s), .cout(cout),
        .busy(busy2), .done(done2), .pass(pass2), .err(err2),
        .vec_cnt(vec_cnt2), .err_cnt(err_cnt2)
`ifdef ADDER_CHECKER_FIRST_FAIL_EN
        , .ff_vld(ff_vld2), .ff_a(ff_a2), .ff_b(ff_b2), .ff_cin(ff_cin2),
        .ff_exp(ff_exp2), .ff_got(ff_got2), .ff_idx(ff_idx2)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one sample for one rising edge; returns at the following negedge
    task automatic drive(input logic [3:0] av, input logic [3:0] bv, input logic cv,
                         input logic [3:0] sv, input logic co);
        a = av; b = bv; cin = cv; s = sv; cout = co;
        vld = 1'b1;
        @(negedge clk);
        vld = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int sum;
        rst_n = 1'b0; start = 1'b0; vld = 1'b0; start2 = 1'b0; vld2 = 1'b0;
        a = '0; b = '0; cin = 1'b0; s = '0; cout = 1'b0;

        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_err", err, 0);
        chk("rst_vec", vec_cnt, 0);
        chk("rst_errcnt", err_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // vld in IDLE is ignored
        drive(4'h1, 4'h1, 1'b0, 4'h2, 1'b0);
        chk("idle_vld_vec", vec_cnt, 0);
        chk("idle_vld_busy", busy, 0);

        // start coincident with vld: the sample is not counted
        start = 1'b1;
        drive(4'h1, 4'h1, 1'b0, 4'h2, 1'b0);
        start = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_vld_vec", vec_cnt, 0);

        // 32 correct samples a=b=i, cin=0/1; start mid-run must be ignored
        n = 0;
        for (int i = 0; i < 16; i++) begin
            for (int c = 0; c < 2; c++) begin
                sum = 2 * i + c;
                if (i == 5 && c == 0) start = 1'b1;
                drive(4'(i), 4'(i), 1'(c), sum[3:0], sum[4]);
                start = 1'b0;
                n++;
                chk("run1_err", err, 0);
                chk("run1_vec", vec_cnt, 32'(n));
            end
        end
        chk("run1_busy_before_last", busy, 1);
        chk("run1_done_before_last", done, 0);
        drive(4'h1, 4'h1, 1'b0, 4'h2, 1'b0);
        chk("run1_done", done, 1);
        chk("run1_pass", pass, 1);
        chk("run1_busy", busy, 0);
        chk("run1_vec_end", vec_cnt, 33);
        chk("run1_errcnt", err_cnt, 0);
        chk("run1_err_end", err, 0);

        // vld in DONE is ignored, counts hold
        drive(4'h3, 4'h3, 1'b0, 4'h5, 1'b0);
        chk("done_vld_vec", vec_cnt, 33);
        chk("done_vld_errcnt", err_cnt, 0);
        chk("done_hold", done, 1);

        // Run 2: error reporting, then reset mid-run after 10 samples
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("run2_busy", busy, 1);
        chk("run2_vec0", vec_cnt, 0);
        chk("run2_pass", pass, 0);
        drive(4'h0, 4'h0, 1'b0, 4'h0, 1'b0);
        chk("run2_ok_err", err, 0);
        drive(4'h3, 4'h3, 1'b0, 4'h5, 1'b0);
        chk("bad33_err", err, 1);
        chk("bad33_errcnt", err_cnt, 1);
`ifdef ADDER_CHECKER_FIRST_FAIL_EN
        chk("ff_vld", ff_vld, 1);
        chk("ff_a", ff_a, 3);
        chk("ff_b", ff_b, 3);
        chk("ff_cin", ff_cin, 0);
        chk("ff_exp", ff_exp, 6);
        chk("ff_got", ff_got, 5);
        chk("ff_idx", ff_idx, 1);
`endif
        @(negedge clk);
        chk("err_one_cycle", err, 0);
        drive(4'hF, 4'hF, 1'b1, 4'hF, 1'b1);
        chk("fff1_ok_err", err, 0);
        chk("fff1_ok_errcnt", err_cnt, 1);
        drive(4'hF, 4'hF, 1'b1, 4'hF, 1'b0);
        chk("fff1_bad_err", err, 1);
        chk("fff1_bad_errcnt", err_cnt, 2);
`ifdef ADDER_CHECKER_FIRST_FAIL_EN
        chk("ff_idx_keep", ff_idx, 1);
        chk("ff_got_keep", ff_got, 5);
`endif
        for (int i = 0; i < 6; i++) begin
            drive(4'(i), 4'h1, 1'b0, 4'(i + 1), 1'b0);
        end
        chk("run2_vec10", vec_cnt, 10);

        // 3 ns reset pulse strictly between clock edges
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_vec", vec_cnt, 0);
        chk("mid_rst_errcnt", err_cnt, 0);
        chk("mid_rst_done", done, 0);
`ifdef ADDER_CHECKER_FIRST_FAIL_EN
        chk("mid_rst_ffvld", ff_vld, 0);
`endif
        #2 rst_n = 1'b1;
        drive(4'h2, 4'h2, 1'b0, 4'h4, 1'b0);
        chk("post_rst_vec", vec_cnt, 0);
        chk("post_rst_busy", busy, 0);

        // Run 3: one mismatch at position 0, run completes with pass=0
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("run3_vec0", vec_cnt, 0);
        chk("run3_busy", busy, 1);
        drive(4'h3, 4'h3, 1'b0, 4'h5, 1'b0);
        chk("run3_err", err, 1);
        chk("run3_errcnt1", err_cnt, 1);
`ifdef ADDER_CHECKER_FIRST_FAIL_EN
        chk("run3_ff_idx", ff_idx, 0);
        chk("run3_ff_exp", ff_exp, 6);
`endif
        for (int i = 0; i < 32; i++) begin
            drive(4'(i), 4'h0, 1'b0, 4'(i), 1'b0);
            chk("run3_ok_err", err, 0);
        end
        chk("run3_done", done, 1);
        chk("run3_pass", pass, 0);
        chk("run3_busy", busy, 0);
        chk("run3_vec", vec_cnt, 33);
        chk("run3_errcnt", err_cnt, 1);

        // Narrow instance: two back-to-back runs of all-wrong samples
        for (int r = 0; r < 2; r++) begin
            start2 = 1'b1;
            @(negedge clk);
            start2 = 1'b0;
            chk("n_busy", busy2, 1);
            chk("n_vec0", vec_cnt2, 0);
            chk("n_errcnt0", err_cnt2, 0);
            for (int k = 0; k < 3; k++) begin
                a = 4'h0; b = 4'h0; cin = 1'b0; s = 4'h1; cout = 1'b0;
                vld2 = 1'b1;
                @(negedge clk);
                vld2 = 1'b0;
                chk("n_err", err2, 1);
            end
            chk("n_errcnt", err_cnt2, 3);
            chk("n_vec", vec_cnt2, 3);
            chk("n_done", done2, 1);
            chk("n_pass", pass2, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/adder_checker.md
ADDER_CHECKER -- requirements
Module: adder_checker

Interface
REQ-001 Parameter WIDTH, 4, operand and sum width of the adder under check.
REQ-002 Parameter NUM_VECTORS, 33, number of valid samples that complete one check run; legal range 1 to 2^CNT_W-1.
REQ-003 Parameter CNT_W, 8, width of vec_cnt and err_cnt.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  one-cycle pulse that begins a run.
REQ-007 vld  in  1  the a/b/cin/s/cout sample is valid this cycle.
REQ-008 a, b  in  WIDTH each  adder operands as driven to the adder.
REQ-009 cin  in  1  adder carry-in.
REQ-010 s  in  WIDTH  adder sum under check.
REQ-011 cout  in  1  adder carry-out under check.
REQ-012 busy  out  1  high while in RUN.
REQ-013 done  out  1  high while in DONE.
REQ-014 pass  out  1  high when done is high and err_cnt is 0.
REQ-015 err  out  1  one-cycle pulse on a mismatching sample.
REQ-016 vec_cnt, err_cnt  out  CNT_W each  samples checked and mismatches found this run.

Function
REQ-017 The block SHALL implement FSM states IDLE, RUN and DONE, with IDLE entered on reset.
REQ-018 IDLE->RUN and DONE->RUN on start, with vec_cnt, err_cnt and capture registers cleared on that same edge.
REQ-019 start while in RUN SHALL be ignored.
REQ-020 vld SHALL be ignored in IDLE and DONE, and in the cycle start is accepted.
REQ-021 Expected result = a + b + cin computed at WIDTH+1 bits; {cout,s} SHALL be compared against it in full.
REQ-022 On each accepted vld edge in RUN: vec_cnt+1; on mismatch, err_cnt+1 and err=1 for exactly the following cycle (latency 1), else err=0.
REQ-023 err_cnt SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-024 The edge that accepts sample number NUM_VECTORS SHALL move RUN->DONE; that sample's result is included in the counts and pass.
REQ-025 busy, done and pass SHALL be registered outputs with no combinational path from inputs.
REQ-026 In DONE, counters and capture registers SHALL hold until start or reset.

Reset
REQ-027 rst_n low SHALL immediately force: state=IDLE, busy=0, done=0, pass=0, err=0, vec_cnt=0, err_cnt=0, capture registers=0, independent of clk.
REQ-028 Reset asserted mid-run SHALL abandon the run; after release the block SHALL stay in IDLE until start.

Configuration
REQ-029 Macro ADDER_CHECKER_FIRST_FAIL_EN SHALL gate first-failure capture.
REQ-030 With ADDER_CHECKER_FIRST_FAIL_EN defined, these ports SHALL exist: ff_vld (out, 1), ff_a (out, WIDTH), ff_b (out, WIDTH), ff_cin (out, 1), ff_exp (out, WIDTH+1), ff_got (out, WIDTH+1), ff_idx (out, CNT_W).
REQ-031 With ADDER_CHECKER_FIRST_FAIL_EN defined, the first mismatch of a run SHALL load these registers and set ff_vld; later mismatches SHALL leave them unchanged.
REQ-032 ff_idx SHALL equal the vec_cnt value before the increment.
REQ-033 Without ADDER_CHECKER_FIRST_FAIL_EN, these ports and registers SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-034 Reset, start, 33 correct samples (a=b=0..15 paired with cin=0/1, plus final 1+1+0) -> done=1, pass=1, vec_cnt=33, err_cnt=0, err never high.
REQ-035 Sample a=3, b=3, cin=0, s=5, cout=0 -> err high one cycle later, err_cnt=1. With the macro: ff_exp=6, ff_got=5, ff_idx equal to the sample position; pass=0 at end of run.
REQ-036 Sample a=F, b=F, cin=1, s=F, cout=1 -> no err. Same sample with cout=0 -> err and err_cnt incremented.
REQ-037 rst_n low for 3 ns after 10 samples, between clock edges -> outputs clear immediately; subsequent vld ignored; counts restart at 0 after start.
REQ-038 vld pulses while in IDLE, start asserted in RUN, and start coincident with vld -> vec_cnt unaffected, state unchanged.
REQ-039 CNT_W=2, NUM_VECTORS=3, all samples wrong, two runs back to back -> err_cnt=3 each run, counters cleared by the second start.
